apb_irq_unit: RTL

APB-programmable interrupt collector that sits directly downstream of the APB timer and the other peripheral interrupt sources. It captures up to NUM_IRQ interrupt lines into a pending register, with a per-line choice of level or rising-edge detection, and applies a software mask. It then presents the lowest-numbered enabled pending interrupt to the core over a request/acknowledge handshake. It lives on the peripheral APB bus as an ordinary 4 KB slave.

---
 rtl/apb_irq_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/apb_irq_unit.sv
`default_nettype none
// ============================================================================
//  Module   : apb_irq_unit
//  Brief    : APB interrupt collector with level/edge capture, masking and a
//             lowest-index-first request/acknowledge handshake to the core.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_irq_unit #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NUM_IRQ        = 8
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [NUM_IRQ-1:0]        irq_src_i,
    output logic                      core_irq_req_o,
    output logic [4:0]                core_irq_id_o,
    input  logic                      core_irq_ack_i,
    input  logic [4:0]                core_irq_ack_id_i
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_ack  = 2'd2;

    localparam logic [2:0] c_idx_mask  = 3'd0;
    localparam logic [2:0] c_idx_pend  = 3'd1;
    localparam logic [2:0] c_idx_pset  = 3'd2;
    localparam logic [2:0] c_idx_pclr  = 3'd3;
    localparam logic [2:0] c_idx_edge  = 3'd4;
    localparam logic [2:0] c_idx_stat  = 3'd5;

    logic [NUM_IRQ-1:0] r_src_q;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] r_edge_sel;
    logic [1:0]         r_state;
    logic [4:0]         r_id_q;
    logic               r_req;

    logic               w_wr_en;
    logic               w_rd_en;
    logic [2:0]         w_idx;
    logic [NUM_IRQ-1:0] w_hw_set;
    logic [NUM_IRQ-1:0] w_sw_set;
    logic [NUM_IRQ-1:0] w_sw_clr;
    logic [NUM_IRQ-1:0] w_ack_clr;
    logic [NUM_IRQ-1:0] w_active;
    logic [4:0]         w_cand;
    logic               w_id_active;
    logic               w_ack_valid;
    logic [1:0]         w_state_n;
    logic [4:0]         w_id_n;
    logic               w_unused;

    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;

    assign w_idx    = PADDR[4:2];
    assign w_wr_en  = PSEL & PENABLE & PWRITE;
    assign w_rd_en  = PSEL & PENABLE & ~PWRITE;
    assign w_unused = ^{PADDR, PWDATA};

    // Edge mode only fires on the cycle the source goes from low to high.
    assign w_hw_set = irq_src_i & (~r_edge_sel | ~r_src_q);
    assign w_sw_set = (w_wr_en && w_idx == c_idx_pset) ? PWDATA[NUM_IRQ-1:0] : '0;
    assign w_sw_clr = (w_wr_en && w_idx == c_idx_pclr) ? PWDATA[NUM_IRQ-1:0] : '0;
    assign w_active = r_pending & r_mask;

    assign w_ack_valid = (r_state == c_st_req) && core_irq_ack_i &&
                         (core_irq_ack_id_i == r_id_q);

    always_comb begin
        w_cand = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_cand = 5'(i);
            end
        end
    end

    always_comb begin
        w_ack_clr   = '0;
        w_id_active = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (r_id_q == 5'(i)) begin
                w_id_active  = w_active[i];
                w_ack_clr[i] = w_ack_valid;
            end
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_id_n    = r_id_q;
        case (r_state)
            c_st_idle: begin
                if (|w_active) begin
                    w_id_n    = w_cand;
                    w_state_n = c_st_req;
                end
            end
            c_st_req: begin
                // A latched request is never preempted; it only ends by ack or withdrawal.
                if (w_ack_valid) begin
                    w_state_n = c_st_ack;
                end else if (!w_id_active) begin
                    w_state_n = c_st_idle;
                end
            end
            c_st_ack: begin
                if (|w_active) begin
                    w_id_n    = w_cand;
                    w_state_n = c_st_req;
                end else begin
                    w_state_n = c_st_idle;
                end
            end
            default: w_state_n = c_st_idle;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_src_q    <= '0;
            r_pending  <= '0;
            r_mask     <= '0;
            r_edge_sel <= '0;
            r_state    <= c_st_idle;
            r_id_q     <= '0;
            r_req      <= 1'b0;
        end else begin
            r_src_q   <= irq_src_i;
            // Any set source wins over any clear in the same cycle.
            r_pending <= w_hw_set | w_sw_set | (r_pending & ~(w_sw_clr | w_ack_clr));
            if (w_wr_en && w_idx == c_idx_mask) begin
                r_mask <= PWDATA[NUM_IRQ-1:0];
            end
            if (w_wr_en && w_idx == c_idx_edge) begin
                r_edge_sel <= PWDATA[NUM_IRQ-1:0];
            end
            r_state <= w_state_n;
            r_id_q  <= w_id_n;
            r_req   <= (w_state_n == c_st_req);
        end
    end

    assign core_irq_req_o = r_req;
    assign core_irq_id_o  = r_id_q;

    always_comb begin
        PRDATA = '0;
        if (w_rd_en) begin
            case (w_idx)
                c_idx_mask: PRDATA = 32'(r_mask);
                c_idx_pend: PRDATA = 32'(r_pending);
                c_idx_edge: PRDATA = 32'(r_edge_sel);
                c_idx_stat: PRDATA = {26'b0, r_req, r_id_q};
                default:    PRDATA = '0;
            endcase
        end
    end

endmodule
`default_nettype wire
